// File: rtl/led_pio_ctrl.sv
// led_pio_ctrl: Avalon-MM output port with DATA/SET/CLEAR/TOGGLE write aliases.
// It also provides per-bit blink enables and a programmable blink prescaler.
// This is a zero-wait-state slave. Read data is combinational and zero-extended.
module led_pio_ctrl #(
    parameter int WIDTH          = 18,
    parameter int PERIOD_W       = 26,
    parameter int DEFAULT_PERIOD = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_BLINK_EN = 3'd1,
        REG_PERIOD   = 3'd2,
        REG_STATUS   = 3'd3,
        REG_SET      = 3'd4,
        REG_CLEAR    = 3'd5,
        REG_TOGGLE   = 3'd6,
        REG_RSVD     = 3'd7
    } reg_addr_e;

    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    blink_en;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic                phase;

    logic                wr;
    logic [WIDTH-1:0]    wd;
    logic [PERIOD_W-1:0] wd_period;
    logic [PERIOD_W-1:0] period_last;
    reg_addr_e           addr;
    logic                unused_writedata;

    assign addr             = reg_addr_e'(address);
    assign wr               = chipselect & ~write_n;
    assign wd               = writedata[WIDTH-1:0];
    assign wd_period        = writedata[PERIOD_W-1:0];
    assign period_last      = period - PERIOD_W'(1);
    assign unused_writedata = ^writedata;

    // DATA register and its SET/CLEAR/TOGGLE write aliases.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (wr) begin
            case (addr)
                REG_DATA:   data <= wd;
                REG_SET:    data <= data | wd;
                REG_CLEAR:  data <= data & ~wd;
                REG_TOGGLE: data <= data ^ wd;
                default:    ;
            endcase
        end
    end

    // Per-bit blink enable register.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_en <= '0;
        end else if (wr && addr == REG_BLINK_EN) begin
            blink_en <= wd;
        end
    end

    // The prescaler flips phase every PERIOD cycles. A PERIOD write restarts it in the "on" phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            period <= PERIOD_W'(DEFAULT_PERIOD);
            cnt    <= '0;
            phase  <= 1'b1;
        end else if (wr && addr == REG_PERIOD) begin
            period <= wd_period;
            cnt    <= '0;
            phase  <= 1'b1;
        end else if (period == '0) begin
            cnt    <= '0;
            phase  <= 1'b1;
        end else if (cnt == period_last) begin
            cnt    <= '0;
            phase  <= ~phase;
        end else begin
            cnt    <= cnt + PERIOD_W'(1);
        end
    end

    // Blinking bits are gated by phase; other bits follow DATA directly.
    always_comb begin
        out_port = data & (~blink_en | {WIDTH{phase}});
    end

    // Zero-extended combinational read mux. SET/CLEAR/TOGGLE read back DATA.
    always_comb begin
        readdata = '0;
        case (addr)
            REG_DATA, REG_SET, REG_CLEAR, REG_TOGGLE: readdata[WIDTH-1:0] = data;
            REG_BLINK_EN: readdata[WIDTH-1:0]    = blink_en;
            REG_PERIOD:   readdata[PERIOD_W-1:0] = period;
            REG_STATUS:   readdata[0]            = phase;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: doc/led_pio_ctrl.md
# led_pio_ctrl

Parametrised Avalon-MM memory-mapped output port for board LEDs and other output pins. It keeps the existing output-port register model: a DATA register with SET and CLEAR write aliases. It adds a TOGGLE alias, a per-bit blink enable, and a programmable blink prescaler, so software can blink any subset of outputs without CPU polling. It sits on the Nios II system interconnect as a zero-wait-state slave and drives `out_port` directly to the pins.

## Interface
- `WIDTH`, 18: number of output bits; legal range 1..32.
- `PERIOD_W`, 26: width of the PERIOD register and the prescaler counter; legal range 1..32.
- `DEFAULT_PERIOD`, 25000000: reset value of PERIOD, in clock cycles per half blink period; must fit in `PERIOD_W` bits.

- `clk`, in, 1: system clock. Every register updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `address`, in, 3: word address of the register.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe; a write happens when `chipselect && !write_n`.
- `writedata`, in, 32: write data; only bits [WIDTH-1:0] are used, except for PERIOD, which uses [PERIOD_W-1:0].
- `readdata`, out, 32: combinational read data, zero-extended.
- `out_port`, out, WIDTH: output pins.

## Operation
- Register map (word addresses):
  - 0 DATA: read/write.
  - 1 BLINK_EN: read/write.
  - 2 PERIOD: read/write.
  - 3 STATUS: read-only; bit0 = phase, other bits 0; writes ignored.
  - 4 SET: on write, data |= wd. Reads return DATA.
  - 5 CLEAR: on write, data &= ~wd. Reads return DATA.
  - 6 TOGGLE: on write, data ^= wd. Reads return DATA.
  - 7: reserved; reads 0, writes ignored.
- Output function, per bit: `out_port[i] = data[i] & (~blink_en[i] | phase)`.
  - A blinking bit is on when phase=1 and off when phase=0.
  - A non-blinking bit follows DATA.
- Prescaler: counter `cnt` (PERIOD_W bits) and a 1-bit `phase`.
  - PERIOD == 0: `cnt` held at 0 and `phase` held at 1, so blinking bits are steady on.
  - PERIOD != 0: each cycle, if `cnt == PERIOD-1` then `cnt <= 0` and `phase` toggles; otherwise `cnt <= cnt+1`.
  - Phase therefore toggles every PERIOD cycles, giving a full blink cycle of 2*PERIOD.
- A write to PERIOD loads the new value and forces `cnt <= 0`, `phase <= 1`. This restarts the blink in phase on and avoids overrun when PERIOD shrinks below the current `cnt`.
- Reset values:
  - data = 0, blink_en = 0, PERIOD = DEFAULT_PERIOD, cnt = 0, phase = 1.
  - Consequently out_port = 0.
  - readdata is combinational and reflects these values.
- Only one write per cycle reaches the block (single-master port), so no write-to-write collisions exist.

## Timing
- Write: register updates on the clock edge where the write strobe is sampled. `out_port` reflects the new value immediately after that edge (0 cycles of added latency beyond the register).
- Read: `readdata` is valid combinationally in the same cycle as `address`, i.e. read latency 0. A read in the same cycle as a write returns the pre-write value.
- Phase toggle coincident with a write to DATA, SET, CLEAR, TOGGLE or BLINK_EN: both take effect on the same edge, independently.
- PERIOD write on the cycle where `cnt == PERIOD-1`: the write wins, giving `cnt = 0` and `phase = 1` with no toggle.
- Reset asserted mid-blink or mid-write: on that edge all state takes its reset values and the write is discarded.
- `cnt` never exceeds PERIOD-1 and never wraps past 2^PERIOD_W - 1.

## Test plan
- **Reset:** hold `reset` 2 cycles, then read addresses 0..7.
  - Expect 0, 0, 25000000, 1, 0, 0, 0, 0.
  - Expect `out_port == 0`.
- **Aliases:** write 0x3F0F0 to DATA, then 0x0000F to SET, then 0x000F0 to CLEAR, then 0x3FFFF to TOGGLE.
  - Expect DATA to read 0x3F0F0, 0x3F0FF, 0x3F00F, 0x00FF0 in turn.
  - `out_port` matches each value one edge after the write.
- **Blink:** with PERIOD=4, DATA=0x3, BLINK_EN=0x1.
  - `out_port[0]` is 1 for 4 cycles, then 0 for 4 cycles, repeating; `out_port[1]` stays 1.
  - STATUS bit0 tracks the same pattern.
- **PERIOD=0:** with blinking bits active, write 0 to PERIOD.
  - Expect phase to stay 1 and blinking bits to stay steady on for at least 20 cycles.
  - Then write 3 to PERIOD; expect the first toggle exactly 3 cycles after the write edge.
- **Collisions:**
  - Write PERIOD=5 on the cycle where `cnt == PERIOD-1`: expect no toggle, `phase = 1`, next toggle 5 cycles later.
  - Write TOGGLE on a phase-toggle edge: both changes are visible on the same edge.
- **Mid-operation reset and parameters:** assert `reset` for 1 cycle during blinking with DATA=0x3FFFF.
  - Expect `out_port = 0` the next cycle and PERIOD back to 25000000.
  - Repeat the full suite with `WIDTH=8`, `PERIOD_W=8`, `DEFAULT_PERIOD=10`; expect `readdata[31:8] == 0` for all reads.
